plot_receiver: RTL and testbench



---
 rtl/plot_receiver_pkg.sv | 40 ++++
 rtl/plot_receiver_fifo.sv | 77 +++++++
 rtl/plot_receiver.sv | 179 +++++++++++++++++
 tb/tb_plot_receiver.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/plot_receiver_pkg.sv
// plot_receiver_pkg
// Shared definitions for the pixel-plot receiver: screen geometry defaults,
// framebuffer widths, FSM state encoding, the buffered plot-entry layout and
// the coordinate-to-address helper.
// Configuration: PLOT_RECV_STATS_EN (see plot_receiver.sv) adds statistics
// counters to the top level; nothing in this package depends on it.
package plot_receiver_pkg;

    localparam int SCREEN_W_DEFAULT = 320;
    localparam int SCREEN_H_DEFAULT = 240;
    localparam int FB_ADDR_W        = 17;
    localparam int COLOUR_W         = 3;

    localparam logic [1:0] S_RUN_ENC   = 2'd0;
    localparam logic [1:0] S_DRAIN_ENC = 2'd1;
    localparam logic [1:0] S_DONE_ENC  = 2'd2;

    typedef enum logic [1:0] {
        S_RUN   = S_RUN_ENC,
        S_DRAIN = S_DRAIN_ENC,
        S_DONE  = S_DONE_ENC
    } state_e;

    typedef struct packed {
        logic [FB_ADDR_W-1:0] addr;
        logic [COLOUR_W-1:0]  colour;
    } plot_entry_t;

    // y*320 + x built from two shifts so no multiplier is inferred; this
    // ties the address layout to a 320-pixel line pitch.
    function automatic logic [FB_ADDR_W-1:0] pixel_addr(input logic [8:0] x,
                                                        input logic [7:0] y);
        logic [FB_ADDR_W-1:0] yWide;
        logic [FB_ADDR_W-1:0] xWide;
        yWide = {9'd0, y};
        xWide = {8'd0, x};
        return (yWide << 8) + (yWide << 6) + xWide;
    endfunction

endpackage

// File: rtl/plot_receiver_fifo.sv
// plot_fifo
// Synchronous FIFO used to buffer plot entries in front of the framebuffer.
// Ports:
//   clk_i, reset_i  clock and asynchronous active-high reset
//   push_i, data_i  write an entry (caller guarantees not full)
//   pop_i           discard the head entry (caller guarantees not empty)
//   data_o          head entry, read combinationally from storage registers
//   full_o, empty_o occupancy flags
//   count_o         number of stored entries (0..DEPTH)
// DEPTH must be a power of two and at least 2 so the pointers wrap naturally.
module plot_fifo #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         data_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (push_i) begin
            wrPtr_d = wrPtr_q + PTR_W'(1);
        end
        if (pop_i) begin
            rdPtr_d = rdPtr_q + PTR_W'(1);
        end
        // A simultaneous push and pop leaves the occupancy unchanged.
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage is cleared on reset so the head output reads zero until the
    // first entry arrives.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (push_i) begin
                mem_q[wrPtr_q] <= data_i;
            end
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    assign data_o  = mem_q[rdPtr_q];
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/plot_receiver.sv
// plot_receiver
// Consumer end of the pixel-plot interface. Accepts (x, y, colour) requests,
// clips them to the visible screen, converts them to a linear framebuffer
// address and buffers them in a small FIFO, issuing one write per cycle to
// the video memory whenever the scan-out arbiter leaves the port free.
// Ports:
//   clk, reset          clock and asynchronous active-high reset
//   x, y, colour, plot  plot request (held-level); accepted when plot && ready
//   ready               request may be accepted at the next edge
//   flush, flush_done   drain request and one-cycle completion pulse
//   mem_busy            memory port unavailable this cycle
//   mem_addr, mem_data  head entry address/colour, stable while stalled
//   mem_we              write strobe; the write occurs at the next edge
// Configuration: defining PLOT_RECV_STATS_EN adds plot_count (accepted
// requests) and clip_count (dropped requests), 16-bit saturating counters.
module plot_receiver
    import plot_receiver_pkg::*;
#(
    parameter int SCREEN_W   = SCREEN_W_DEFAULT,
    parameter int SCREEN_H   = SCREEN_H_DEFAULT,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [8:0]           x,
    input  logic [7:0]           y,
    input  logic [COLOUR_W-1:0]  colour,
    input  logic                 plot,
    output logic                 ready,
    input  logic                 flush,
    output logic                 flush_done,
    input  logic                 mem_busy,
    output logic [FB_ADDR_W-1:0] mem_addr,
    output logic [COLOUR_W-1:0]  mem_data,
    output logic                 mem_we
`ifdef PLOT_RECV_STATS_EN
    ,
    output logic [15:0]          plot_count,
    output logic [15:0]          clip_count
`endif
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [8:0] SCREEN_W_V = 9'(SCREEN_W);
    localparam logic [8:0] SCREEN_H_V = 9'(SCREEN_H);

    state_e      state_q, state_d;
    logic        s1Valid_q, s1Valid_d;
    logic        s1Clip_q, s1Clip_d;
    plot_entry_t s1Entry_q, s1Entry_d;

    logic             accept;
    logic             fifoPush, fifoPop, fifoFull, fifoEmpty;
    logic [CNT_W-1:0] fifoCount;
    logic [CNT_W-1:0] occupancy;
    plot_entry_t      fifoHead;

    // Counting the stage-1 entry as occupied means a request accepted now
    // always finds a FIFO slot, whether or not it is later clipped.
    assign occupancy = fifoCount + CNT_W'(s1Valid_q);
    assign ready     = !reset && (state_q == S_RUN) && !fifoFull
                       && (occupancy < CNT_W'(FIFO_DEPTH));
    assign accept    = plot && ready;

    always_comb begin
        s1Valid_d = accept;
        s1Clip_d  = s1Clip_q;
        s1Entry_d = s1Entry_q;
        if (accept) begin
            s1Clip_d         = (x >= SCREEN_W_V) || ({1'b0, y} >= SCREEN_H_V);
            s1Entry_d.addr   = pixel_addr(x, y);
            s1Entry_d.colour = colour;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1Valid_q <= 1'b0;
            s1Clip_q  <= 1'b0;
            s1Entry_q <= '0;
        end else begin
            s1Valid_q <= s1Valid_d;
            s1Clip_q  <= s1Clip_d;
            s1Entry_q <= s1Entry_d;
        end
    end

    assign fifoPush = s1Valid_q && !s1Clip_q;
    assign fifoPop  = !fifoEmpty && !mem_busy;

    plot_fifo #(
        .WIDTH ($bits(plot_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .reset_i (reset),
        .push_i  (fifoPush),
        .pop_i   (fifoPop),
        .data_i  (s1Entry_q),
        .data_o  (fifoHead),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty),
        .count_o (fifoCount)
    );

    // The head comes straight from FIFO registers, so address and data stay
    // put while stalled; the strobe is the pop itself, which the async FIFO
    // reset forces low the moment reset asserts.
    assign mem_addr = fifoHead.addr;
    assign mem_data = fifoHead.colour;
    assign mem_we   = fifoPop;

    always_comb begin
        state_d    = state_q;
        flush_done = 1'b0;
        case (state_q)
            S_RUN: begin
                if (flush) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!s1Valid_q && fifoEmpty) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                flush_done = 1'b1;
                state_d    = S_RUN;
            end
            default: state_d = S_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_RUN;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef PLOT_RECV_STATS_EN
    logic [15:0] plotCnt_q, plotCnt_d;
    logic [15:0] clipCnt_q, clipCnt_d;

    // Counters clear on the edge that ends the S_DONE cycle, after the host
    // has had the chance to sample them alongside flush_done.
    always_comb begin
        plotCnt_d = plotCnt_q;
        clipCnt_d = clipCnt_q;
        if (state_q == S_DONE) begin
            plotCnt_d = '0;
            clipCnt_d = '0;
        end else begin
            if (accept && (plotCnt_q != 16'hFFFF)) begin
                plotCnt_d = plotCnt_q + 16'd1;
            end
            if (s1Valid_q && s1Clip_q && (clipCnt_q != 16'hFFFF)) begin
                clipCnt_d = clipCnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            plotCnt_q <= '0;
            clipCnt_q <= '0;
        end else begin
            plotCnt_q <= plotCnt_d;
            clipCnt_q <= clipCnt_d;
        end
    end

    assign plot_count = plotCnt_q;
    assign clip_count = clipCnt_q;
`endif

endmodule

// File: tb/tb_plot_receiver.sv
// tb_plot_receiver
// Self-checking bench for plot_receiver. A behavioural model turns every
// accepted request into an expected framebuffer write (y*320+x, colour) or
// nothing if off-screen; a monitor compares each observed write with the
// model queue, while directed steps check timing, back-pressure, flush and
// reset behaviour, followed by a randomized run.
module tb_plot_receiver;

    logic        clk;
    logic        reset;
    logic [8:0]  x;
    logic [7:0]  y;
    logic [2:0]  colour;
    logic        plot;
    logic        ready;
    logic        flush;
    logic        flush_done;
    logic        mem_busy;
    logic [16:0] mem_addr;
    logic [2:0]  mem_data;
    logic        mem_we;
`ifdef PLOT_RECV_STATS_EN
    logic [15:0] plot_count;
    logic [15:0] clip_count;
`endif

    plot_receiver dut (
        .clk        (clk),
        .reset      (reset),
        .x          (x),
        .y          (y),
        .colour     (colour),
        .plot       (plot),
        .ready      (ready),
        .flush      (flush),
        .flush_done (flush_done),
        .mem_busy   (mem_busy),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .mem_we     (mem_we)
`ifdef PLOT_RECV_STATS_EN
        ,
        .plot_count (plot_count),
        .clip_count (clip_count)
`endif
    );

    typedef struct {
        int addr;
        int col;
    } exp_t;

    exp_t expQ[$];
    int   wrAddrLog[$];
    int   wrDataLog[$];
    int   wrCycleLog[$];
    int   cycleNum     = 0;
    int   writeCount   = 0;
    int   acceptCount  = 0;
    int   lastAccCycle = 0;
    int   assertCount  = 0;
    int   failCount    = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cycleNum <= cycleNum + 1;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Monitor and reference model, sampled mid-cycle when everything is settled.
    always @(negedge clk) begin
        if (reset) begin
            expQ.delete();
            checkOutput("we_in_reset", int'(mem_we), 0);
        end else begin
            if (mem_busy) checkOutput("we_when_busy", int'(mem_we), 0);
            if (mem_we) begin
                checkOutput("write_expected", int'(expQ.size() > 0), 1);
                if (expQ.size() > 0) begin
                    checkOutput("write_addr", int'(mem_addr), expQ[0].addr);
                    checkOutput("write_data", int'(mem_data), expQ[0].col);
                    void'(expQ.pop_front());
                end
                wrAddrLog.push_back(int'(mem_addr));
                wrDataLog.push_back(int'(mem_data));
                wrCycleLog.push_back(cycleNum);
                writeCount++;
            end
            if (plot && ready) begin
                acceptCount++;
                lastAccCycle = cycleNum;
                if (int'(x) < 320 && int'(y) < 240) begin
                    expQ.push_back('{addr: int'(y) * 320 + int'(x), col: int'(colour)});
                end
            end
        end
    end

    // Inputs change just after the rising edge; returns just after the
    // falling edge so the caller sees settled outputs for this cycle.
    task automatic applyStimulus(input bit p, input int xx, input int yy, input int cc,
                                 input bit busy, input bit fl);
        @(posedge clk);
        #1;
        plot     = p;
        x        = 9'(xx);
        y        = 8'(yy);
        colour   = 3'(cc);
        mem_busy = busy;
        flush    = fl;
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n, input bit busy);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 0, 0, 0, busy, 1'b0);
    endtask

    initial begin
        int wr0, acc0, idx, pulses, doneCyc, readyAfter;
        bit readyBad, seenDone, afterPending;
`ifdef PLOT_RECV_STATS_EN
        int pc0, cc0;
`endif
        reset = 1'b1; plot = 1'b0; x = '0; y = '0; colour = '0;
        flush = 1'b0; mem_busy = 1'b0;

        // Reset values
        @(negedge clk); #1;
        checkOutput("reset_ready", int'(ready), 0);
        checkOutput("reset_we", int'(mem_we), 0);
        checkOutput("reset_addr", int'(mem_addr), 0);
        checkOutput("reset_data", int'(mem_data), 0);
        checkOutput("reset_flush_done", int'(flush_done), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk); #1;
        checkOutput("ready_after_reset", int'(ready), 1);

        // Single plot: two-cycle latency, address 965
        wr0 = writeCount;
        applyStimulus(1'b1, 5, 3, 5, 1'b0, 1'b0);
        idle(4, 1'b0);
        checkOutput("single_write_count", writeCount - wr0, 1);
        checkOutput("single_latency", wrCycleLog[$] - lastAccCycle, 2);
        checkOutput("single_addr", wrAddrLog[$], 965);
        checkOutput("single_data", wrDataLog[$], 5);

        // Clipped plots
        wr0 = writeCount; acc0 = acceptCount;
`ifdef PLOT_RECV_STATS_EN
        pc0 = int'(plot_count); cc0 = int'(clip_count);
`endif
        applyStimulus(1'b1, 320, 10, 2, 1'b0, 1'b0);
        applyStimulus(1'b1, 0, 240, 3, 1'b0, 1'b0);
        idle(4, 1'b0);
        checkOutput("clip_no_write", writeCount - wr0, 0);
        checkOutput("clip_accepted", acceptCount - acc0, 2);
`ifdef PLOT_RECV_STATS_EN
        checkOutput("clip_count", int'(clip_count) - cc0, 2);
        checkOutput("plot_count", int'(plot_count) - pc0, 2);
`endif

        // Back-pressure: plot held with memory busy
        idx = 0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 10 + idx, 20, idx, 1'b1, 1'b0);
            if (ready) idx++;
        end
        checkOutput("busy_accepts", idx, 4);
        checkOutput("busy_ready_low", int'(ready), 0);
        wr0 = writeCount;
        idle(6, 1'b0);
        checkOutput("busy_drain_writes", writeCount - wr0, 4);
        checkOutput("busy_first_addr", wrAddrLog[wr0], 6410);
        checkOutput("busy_last_addr", wrAddrLog[wr0 + 3], 6413);
        checkOutput("busy_consecutive", wrCycleLog[wr0 + 3] - wrCycleLog[wr0], 3);

        // Streaming along the bottom row
        wr0 = writeCount; idx = 0;
        for (int i = 0; i < 30 && idx < 8; i++) begin
            applyStimulus(1'b1, idx, 239, idx, 1'b0, 1'b0);
            if (ready) idx++;
        end
        idle(4, 1'b0);
        checkOutput("stream_writes", writeCount - wr0, 8);
        checkOutput("stream_first_addr", wrAddrLog[wr0], 76480);
        checkOutput("stream_last_addr", wrAddrLog[wr0 + 7], 76487);
        checkOutput("stream_consecutive", wrCycleLog[wr0 + 7] - wrCycleLog[wr0], 7);

        // Flush with three plots queued behind a busy port
        wr0 = writeCount;
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 100 + i, 50, i + 1, 1'b1, 1'b0);
        applyStimulus(1'b0, 0, 0, 0, 1'b1, 1'b1);
        pulses = 0; doneCyc = -1; readyAfter = 0;
        readyBad = 1'b0; seenDone = 1'b0; afterPending = 1'b0;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b0, 0, 0, 0, 1'b0, 1'b0);
            if (afterPending) begin
                readyAfter   = int'(ready);
                afterPending = 1'b0;
            end
            if (!seenDone && ready) readyBad = 1'b1;
            if (flush_done) begin
                pulses++;
                if (!seenDone) begin
                    seenDone     = 1'b1;
                    doneCyc      = cycleNum;
                    afterPending = 1'b1;
                end
            end
        end
        checkOutput("flush_writes", writeCount - wr0, 3);
        checkOutput("flush_done_pulses", pulses, 1);
        checkOutput("flush_ready_held_low", int'(readyBad), 0);
        checkOutput("flush_ready_after", readyAfter, 1);
        checkOutput("flush_done_delay", doneCyc - wrCycleLog[$], 2);
`ifdef PLOT_RECV_STATS_EN
        checkOutput("flush_stats_cleared", int'(plot_count), 0);
`endif

        // Reset with entries queued
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 200 + i, 7, 6, 1'b1, 1'b0);
        idle(2, 1'b1);
        @(posedge clk); #1;
        reset = 1'b1; mem_busy = 1'b0; plot = 1'b0;
        #1;
        checkOutput("reset_we_immediate", int'(mem_we), 0);
        checkOutput("reset_ready_low", int'(ready), 0);
        wr0 = writeCount;
        idle(2, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk); #1;
        checkOutput("reset_ready_first_cycle", int'(ready), 1);
        idle(6, 1'b0);
        checkOutput("reset_no_writes", writeCount - wr0, 0);

        // Randomized traffic against the model
        for (int i = 0; i < 300; i++) begin
            applyStimulus($urandom_range(0, 9) < 7, $urandom_range(0, 340),
                          $urandom_range(0, 250), $urandom_range(0, 7),
                          $urandom_range(0, 9) < 3, 1'b0);
        end
        idle(12, 1'b0);
        checkOutput("random_all_written", expQ.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
